// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr0,
    StHdr1,
    StData,
    StWrite,
    StDone,
    StErr
  } state_e;

  localparam int unsigned MaxWords     = 256;
  localparam int unsigned HdrW         = 16;
  localparam int unsigned LanesPerWord = 4;

endpackage

// File: rtl/word_packer.sv
// Packs successive bytes little-endian into a 32-bit word; full_o flags the completing write.
module word_packer
  import imem_loader_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        clr_i,
  input  logic                        wr_i,
  input  logic [7:0]                  byte_i,
  output logic [LanesPerWord*8-1:0]   word_o,
  output logic                        full_o
);

  logic [LanesPerWord-1:0][7:0] lane_q, lane_d;
  logic [1:0]                   idx_q, idx_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lane_q <= '0;
      idx_q  <= '0;
    end else begin
      lane_q <= lane_d;
      idx_q  <= idx_d;
    end
  end

  // Clearing only rewinds the index; lane contents are simply overwritten later.
  always_comb begin
    lane_d = lane_q;
    idx_d  = idx_q;
    if (clr_i) begin
      idx_d = '0;
    end else if (wr_i) begin
      lane_d[idx_q] = byte_i;
      idx_d         = idx_q + 2'd1;
    end
  end

  assign word_o = lane_q;
  assign full_o = wr_i && (idx_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Parses a 16-bit word-count header, then packs and writes instruction words into
// instruction memory, holding the core in reset until the image is complete.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MAX_WORDS = MaxWords
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_as,
  output logic [31:0]       imem_wd,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  // Word index carries one extra bit so a full-size count can be compared.
  localparam int unsigned WIdxW = ADDR_W - 1;

  state_e             state_q, state_d;
  logic [HdrW-1:0]    count_q, count_d;
  logic [WIdxW-1:0]   widx_q, widx_d;
  logic [ADDR_W-1:0]  as_q, as_d;
  logic [31:0]        wd_q, wd_d;

  logic               xfer;
  logic               restart;
  logic               pack_full;
  logic [31:0]        pack_word;
  logic [HdrW-1:0]    hdr_count;
  logic [HdrW-1:0]    widx_next;
  logic [ADDR_W-1:0]  cur_as;

  assign xfer      = byte_valid && byte_ready;
  assign restart   = start && (state_q inside {StIdle, StDone, StErr});
  assign hdr_count = {byte_data, count_q[7:0]};
  assign widx_next = HdrW'(widx_q) + HdrW'(1);
  assign cur_as    = {widx_q[WIdxW-2:0], 2'b00};

  word_packer u_packer (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (restart || (state_q == StWrite)),
    .wr_i   (xfer && (state_q == StData)),
    .byte_i (byte_data),
    .word_o (pack_word),
    .full_o (pack_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      count_q <= '0;
      widx_q  <= '0;
      as_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      widx_q  <= widx_d;
      as_q    <= as_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    widx_d  = widx_q;
    as_d    = as_q;
    wd_d    = wd_q;
    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StHdr0;
          count_d = '0;
          widx_d  = '0;
        end
      end
      StHdr0: begin
        if (xfer) begin
          count_d[7:0] = byte_data;
          state_d      = StHdr1;
        end
      end
      StHdr1: begin
        if (xfer) begin
          count_d = hdr_count;
          if ((hdr_count == '0) || (hdr_count > HdrW'(MAX_WORDS))) state_d = StErr;
          else                                                     state_d = StData;
        end
      end
      StData: begin
        if (pack_full) state_d = StWrite;
      end
      StWrite: begin
        // Latch the written word so the memory port stays stable until the next write.
        as_d    = cur_as;
        wd_d    = pack_word;
        widx_d  = widx_q + WIdxW'(1);
        state_d = (widx_next == count_q) ? StDone : StData;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    byte_ready = state_q inside {StHdr0, StHdr1, StData};
    imem_we    = (state_q == StWrite);
    imem_as    = imem_we ? cur_as : as_q;
    imem_wd    = imem_we ? pack_word : wd_q;
    cpu_hold   = (state_q != StDone);
    done       = (state_q == StDone);
    err        = (state_q == StErr);
  end

endmodule
